// File: rtl/mat_operand_streamer.sv
// mat_operand_streamer
// Purpose: transmit side of the mat_mult operand interface. Holds a 4x4
//   unsigned X matrix and a 4x4 signed Q1.7 Y matrix in local registers and
//   streams them as 16 beats. Beat (i,j) carries row i of X on A00..A03 and
//   column j of Y on B00..B03.
// Ports:
//   clk_80, rst_80          clock, synchronous active-high reset
//   wr_en_80/wr_sel_80      matrix write strobe, 0 = X, 1 = Y (IDLE only)
//   wr_addr_80/wr_data_80   element index {row,col} and write data
//   start_80                begin a stream (IDLE only)
//   out_ready_80            sink ready; beat advances on valid & ready
//   repeat_80               (only with MAT_FEED_REPEAT_EN) loop back to beat
//                           (0,0) after (3,3) instead of finishing
//   out_valid_80            A/B buses carry a valid beat
//   A00_80..A03_80          X row elements of the current beat
//   B00_80..B03_80          Y column elements of the current beat
//   row_idx_80/col_idx_80   (i,j) of the current beat
//   last_80                 high with beat (3,3)
//   busy_80                 high in LOAD and STREAM
//   done_80                 one-cycle pulse after the beat-(3,3) handshake
// Configuration: define MAT_FEED_REPEAT_EN to add the repeat_80 input.
module mat_operand_streamer #(
  parameter int A_W = 9,
  parameter int B_W = 8,
  parameter int N   = 4
) (
  input  logic           clk_80,
  input  logic           rst_80,
  input  logic           wr_en_80,
  input  logic           wr_sel_80,
  input  logic [3:0]     wr_addr_80,
  input  logic [A_W-1:0] wr_data_80,
  input  logic           start_80,
  input  logic           out_ready_80,
`ifdef MAT_FEED_REPEAT_EN
  input  logic           repeat_80,
`endif
  output logic           out_valid_80,
  output logic [A_W-1:0] A00_80,
  output logic [A_W-1:0] A01_80,
  output logic [A_W-1:0] A02_80,
  output logic [A_W-1:0] A03_80,
  output logic [B_W-1:0] B00_80,
  output logic [B_W-1:0] B01_80,
  output logic [B_W-1:0] B02_80,
  output logic [B_W-1:0] B03_80,
  output logic [1:0]     row_idx_80,
  output logic [1:0]     col_idx_80,
  output logic           last_80,
  output logic           busy_80,
  output logic           done_80
);

  localparam int NE = N * N;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_e;

  state_e         state_q;
  logic [A_W-1:0] x_q [NE];
  logic [B_W-1:0] y_q [NE];
  logic [A_W-1:0] a_q [4];
  logic [B_W-1:0] b_q [4];
  logic [1:0]     row_q;
  logic [1:0]     col_q;
  logic           valid_q;
  logic           last_q;
  logic           busy_q;
  logic           done_q;

  logic [1:0]     tgt_row_d;
  logic [1:0]     tgt_col_d;
  logic [A_W-1:0] a_d [4];
  logic [B_W-1:0] b_d [4];
  logic           hs_s;
  logic           wrap_s;
  logic           rep_en_s;

`ifdef MAT_FEED_REPEAT_EN
  assign rep_en_s = repeat_80;
`else
  assign rep_en_s = 1'b0;
`endif

  // valid_q is high exactly in STREAM, so the handshake reduces to ready there
  assign hs_s   = (state_q == S_STREAM) && out_ready_80;
  assign wrap_s = (row_q == 2'd3) && (col_q == 2'd3);

  // Index of the beat to present next: (0,0) on entry or wrap, else j then i
  always_comb begin
    tgt_row_d = row_q;
    tgt_col_d = col_q;
    if ((state_q == S_LOAD) || (hs_s && wrap_s)) begin
      tgt_row_d = 2'd0;
      tgt_col_d = 2'd0;
    end else if (hs_s) begin
      tgt_col_d = col_q + 2'd1;
      tgt_row_d = (col_q == 2'd3) ? (row_q + 2'd1) : row_q;
    end else begin
      tgt_row_d = row_q;
      tgt_col_d = col_q;
    end
  end

  // Gather the next beat: X row tgt_row_d and Y column tgt_col_d
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a_d[k] = x_q[{tgt_row_d, 2'(k)}];
      b_d[k] = y_q[{2'(k), tgt_col_d}];
    end
  end

  // Matrix storage; only writable while idle so a running stream is coherent
  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      for (int k = 0; k < NE; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else if ((state_q == S_IDLE) && wr_en_80) begin
      if (wr_sel_80) begin
        y_q[wr_addr_80] <= wr_data_80[B_W-1:0];
      end else begin
        x_q[wr_addr_80] <= wr_data_80;
      end
    end
  end

  // Control FSM with registered beat outputs
  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_80) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_STREAM;
          valid_q <= 1'b1;
          row_q   <= tgt_row_d;
          col_q   <= tgt_col_d;
          last_q  <= (tgt_row_d == 2'd3) && (tgt_col_d == 2'd3);
          for (int k = 0; k < 4; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
          end
        end
        S_STREAM: begin
          if (out_ready_80) begin
            if (wrap_s && !rep_en_s) begin
              // Final beat accepted: keep A/B/idx, drop valid, pulse done
              state_q <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q  <= tgt_row_d;
              col_q  <= tgt_col_d;
              last_q <= (tgt_row_d == 2'd3) && (tgt_col_d == 2'd3);
              for (int k = 0; k < 4; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid_80 = valid_q;
  assign A00_80       = a_q[0];
  assign A01_80       = a_q[1];
  assign A02_80       = a_q[2];
  assign A03_80       = a_q[3];
  assign B00_80       = b_q[0];
  assign B01_80       = b_q[1];
  assign B02_80       = b_q[2];
  assign B03_80       = b_q[3];
  assign row_idx_80   = row_q;
  assign col_idx_80   = col_q;
  assign last_80      = last_q;
  assign busy_80      = busy_q;
  assign done_80      = done_q;

endmodule

// File: tb/tb_mat_operand_streamer.sv
// Directed testbench for mat_operand_streamer: loads the reference X/Y
// matrices, streams them with and without back-pressure, and exercises
// write/start interaction, reset mid-stream, held start and (when built with
// MAT_FEED_REPEAT_EN) back-to-back repeat streams.
module tb_mat_operand_streamer;

  localparam int A_W = 9;
  localparam int B_W = 8;

  logic           clk_80 = 1'b0;
  logic           rst_80;
  logic           wr_en_80;
  logic           wr_sel_80;
  logic [3:0]     wr_addr_80;
  logic [A_W-1:0] wr_data_80;
  logic           start_80;
  logic           out_ready_80;
  logic           repeat_80;
  logic           out_valid_80;
  logic [A_W-1:0] A00_80, A01_80, A02_80, A03_80;
  logic [B_W-1:0] B00_80, B01_80, B02_80, B03_80;
  logic [1:0]     row_idx_80, col_idx_80;
  logic           last_80, busy_80, done_80;

  mat_operand_streamer #(.A_W(A_W), .B_W(B_W), .N(4)) dut (
    .clk_80(clk_80), .rst_80(rst_80),
    .wr_en_80(wr_en_80), .wr_sel_80(wr_sel_80),
    .wr_addr_80(wr_addr_80), .wr_data_80(wr_data_80),
    .start_80(start_80), .out_ready_80(out_ready_80),
`ifdef MAT_FEED_REPEAT_EN
    .repeat_80(repeat_80),
`endif
    .out_valid_80(out_valid_80),
    .A00_80(A00_80), .A01_80(A01_80), .A02_80(A02_80), .A03_80(A03_80),
    .B00_80(B00_80), .B01_80(B01_80), .B02_80(B02_80), .B03_80(B03_80),
    .row_idx_80(row_idx_80), .col_idx_80(col_idx_80),
    .last_80(last_80), .busy_80(busy_80), .done_80(done_80)
  );

  always #5 clk_80 = ~clk_80;

  int checks   = 0;
  int failures = 0;

  // Reference data: X row-major, Y listed column by column
  int xr_init [16] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110, 120, 130, 140, 150, 160};
  int yc_init [16] = '{13, 77, 102, 205, 26, 166, 90, 38, 38, 154, 77, 230, 192, 115, 64, 13};
  int x_m  [16];
  int yc_m [16];

  logic [35:0] a_cap    [40];
  logic [31:0] b_cap    [40];
  logic [3:0]  idx_cap  [40];
  logic        last_cap [40];
  int          hs_cyc   [40];
  int          nbeats, done_cnt, done_cyc, cap_cyc;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] exp_a(input int i);
    exp_a = {9'(x_m[i*4]), 9'(x_m[i*4+1]), 9'(x_m[i*4+2]), 9'(x_m[i*4+3])};
  endfunction

  function automatic logic [31:0] exp_b(input int j);
    exp_b = {8'(yc_m[j*4]), 8'(yc_m[j*4+1]), 8'(yc_m[j*4+2]), 8'(yc_m[j*4+3])};
  endfunction

  function automatic logic [35:0] cur_a();
    cur_a = {A00_80, A01_80, A02_80, A03_80};
  endfunction

  function automatic logic [31:0] cur_b();
    cur_b = {B00_80, B01_80, B02_80, B03_80};
  endfunction

  task automatic mwrite(input logic sel, input logic [3:0] addr, input int data);
    wr_en_80 = 1'b1; wr_sel_80 = sel; wr_addr_80 = addr; wr_data_80 = 9'(data);
    @(posedge clk_80); #1;
    wr_en_80 = 1'b0;
  endtask

  task automatic pulse_start();
    start_80 = 1'b1;
    @(posedge clk_80); #1;
    start_80 = 1'b0;
  endtask

  // Runs the sink side: records every handshake until done_80, stop_at beats,
  // or the cycle budget. Optional stall, in-stream write and repeat release.
  task automatic capture(input int stall_at, input int stall_n, input int stop_at,
                         input int wr_at, input int rep_clr_at);
    int stalls;
    stalls = 0; nbeats = 0; done_cnt = 0; done_cyc = -1; cap_cyc = 0;
    while (cap_cyc < 400) begin
      if (nbeats == stop_at) break;
      if (done_80 === 1'b1) begin
        done_cnt++; done_cyc = cap_cyc;
        break;
      end
      if (nbeats == stall_at && stalls < stall_n) begin
        out_ready_80 = 1'b0; stalls++;
      end else begin
        out_ready_80 = 1'b1;
      end
      if (nbeats == wr_at) begin
        wr_en_80 = 1'b1; wr_sel_80 = 1'b0; wr_addr_80 = 4'd0; wr_data_80 = 9'd7;
      end
      if (nbeats == rep_clr_at) repeat_80 = 1'b0;
      if (out_valid_80 && out_ready_80) begin
        if (nbeats < 40) begin
          a_cap[nbeats] = cur_a(); b_cap[nbeats] = cur_b();
          idx_cap[nbeats] = {row_idx_80, col_idx_80};
          last_cap[nbeats] = last_80; hs_cyc[nbeats] = cap_cyc;
        end
        nbeats++;
      end else if (out_valid_80) begin
        check_eq("stall_hold_a", cur_a(), exp_a((nbeats / 4) % 4));
        check_eq("stall_hold_b", cur_b(), exp_b(nbeats % 4));
      end
      @(posedge clk_80); #1;
      wr_en_80 = 1'b0;
      cap_cyc++;
    end
    out_ready_80 = 1'b1;
    check_eq("capture_bound", 80'(cap_cyc < 400), 80'd1);
  endtask

  // Compares every captured beat against the bench's matrix model
  task automatic verify_beats(input string tag, input int n);
    for (int b = 0; b < n; b++) begin
      int i, j;
      i = (b / 4) % 4; j = b % 4;
      check_eq($sformatf("%s_beat%0d", tag, b),
               {a_cap[b], b_cap[b], idx_cap[b], last_cap[b]},
               {exp_a(i), exp_b(j), 4'(i * 4 + j), (j == 3 && i == 3) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic check_done_tail(input string tag);
    check_eq({tag, "_beats"}, 80'(nbeats), 80'd16);
    check_eq({tag, "_done_seen"}, 80'(done_cnt), 80'd1);
    check_eq({tag, "_done_lat"}, 80'(done_cyc), 80'(hs_cyc[15] + 1));
    check_eq({tag, "_done_busy"}, 80'(busy_80), 80'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_80 = 1'b1; wr_en_80 = 1'b0; wr_sel_80 = 1'b0; wr_addr_80 = 4'd0;
    wr_data_80 = 9'd0; start_80 = 1'b0; out_ready_80 = 1'b1; repeat_80 = 1'b0;
    repeat (3) @(posedge clk_80);
    #1 rst_80 = 1'b0;

    // Reset state
    check_eq("rst_valid", 80'(out_valid_80), 80'd0);
    check_eq("rst_flags", {77'd0, busy_80, done_80, last_80}, 80'd0);
    check_eq("rst_data", {cur_a(), cur_b(), row_idx_80, col_idx_80}, 80'd0);

    // Load reference matrices
    for (int k = 0; k < 16; k++) begin
      x_m[k] = xr_init[k]; yc_m[k] = yc_init[k];
    end
    for (int k = 0; k < 16; k++) mwrite(1'b0, 4'(k), x_m[k]);
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) mwrite(1'b1, 4'(k * 4 + j), yc_m[j * 4 + k]);

    // Plain stream, ready always high
    pulse_start();
    check_eq("load_valid", 80'(out_valid_80), 80'd0);
    check_eq("load_busy", 80'(busy_80), 80'd1);
    capture(-1, 0, -1, -1, -1);
    check_eq("first_beat_lat", 80'(hs_cyc[0]), 80'd1);
    check_eq("b0_a", a_cap[0], {9'd10, 9'd20, 9'd30, 9'd40});
    check_eq("b0_b", b_cap[0], {8'd13, 8'd77, 8'd102, 8'd205});
    check_eq("b4_a", a_cap[4], {9'd50, 9'd60, 9'd70, 9'd80});
    check_eq("b4_b", b_cap[4], {8'd13, 8'd77, 8'd102, 8'd205});
    check_eq("b15_a", a_cap[15], {9'd130, 9'd140, 9'd150, 9'd160});
    check_eq("b15_b", b_cap[15], {8'd192, 8'd115, 8'd64, 8'd13});
    check_eq("b15_last", 80'(last_cap[15]), 80'd1);
    check_eq("b14_last", 80'(last_cap[14]), 80'd0);
    check_done_tail("plain");
    check_eq("done_hold", {cur_a(), row_idx_80, col_idx_80, out_valid_80},
             {9'd130, 9'd140, 9'd150, 9'd160, 2'd3, 2'd3, 1'b0});
    verify_beats("plain", 16);
    @(posedge clk_80); #1;
    check_eq("done_width", 80'(done_80), 80'd0);

    // Back-pressure: ready low 3 cycles while beat 5 is on the bus
    pulse_start();
    capture(5, 3, -1, -1, -1);
    check_done_tail("stall");
    check_eq("stall_b5_a", a_cap[5], {9'd50, 9'd60, 9'd70, 9'd80});
    check_eq("stall_b5_b", b_cap[5], {8'd26, 8'd166, 8'd90, 8'd38});
    check_eq("stall_gap", 80'(hs_cyc[5] - hs_cyc[4]), 80'd4);
    verify_beats("stall", 16);
    @(posedge clk_80); #1;

`ifdef MAT_FEED_REPEAT_EN
    // Repeat: back-to-back streams, released after beat 20
    repeat_80 = 1'b1;
    pulse_start();
    capture(-1, 0, -1, -1, 20);
    check_eq("rep_beats", 80'(nbeats), 80'd32);
    check_eq("rep_done_seen", 80'(done_cnt), 80'd1);
    check_eq("rep_no_gap", 80'(hs_cyc[16] - hs_cyc[15]), 80'd1);
    check_eq("rep_b16_a", a_cap[16], {9'd10, 9'd20, 9'd30, 9'd40});
    check_eq("rep_b16_idx", 80'(idx_cap[16]), 80'd0);
    check_eq("rep_done_lat", 80'(done_cyc), 80'(hs_cyc[31] + 1));
    verify_beats("rep", 32);
    @(posedge clk_80); #1;
`endif

    // Write in the start cycle is visible; write mid-stream is ignored
    wr_en_80 = 1'b1; wr_sel_80 = 1'b0; wr_addr_80 = 4'd0; wr_data_80 = 9'd255;
    start_80 = 1'b1;
    @(posedge clk_80); #1;
    wr_en_80 = 1'b0; start_80 = 1'b0;
    x_m[0] = 255;
    capture(-1, 0, -1, 3, -1);
    check_eq("wr_start_a00", 80'(a_cap[0][35:27]), 80'd255);
    check_done_tail("wrstart");
    verify_beats("wrstart", 16);
    @(posedge clk_80); #1;

    // Start held high across the whole stream
    start_80 = 1'b1;
    @(posedge clk_80); #1;
    capture(-1, 0, -1, -1, -1);
    check_done_tail("held");
    check_eq("wr_ignored_a00", 80'(a_cap[0][35:27]), 80'd255);
    verify_beats("held", 16);
    @(posedge clk_80); #1;
    check_eq("held_idle", 80'(busy_80), 80'd0);
    @(posedge clk_80); #1;
    check_eq("held_reload", {78'd0, busy_80, out_valid_80}, {78'd0, 1'b1, 1'b0});
    start_80 = 1'b0;
    capture(-1, 0, -1, -1, -1);
    check_done_tail("held2");
    @(posedge clk_80); #1;

    // Reset while beat 7 is on the bus
    pulse_start();
    capture(-1, 0, 7, -1, -1);
    check_eq("pre_rst_beats", 80'(nbeats), 80'd7);
    rst_80 = 1'b1;
    @(posedge clk_80); #1;
    rst_80 = 1'b0;
    check_eq("mid_rst_flags", {76'd0, out_valid_80, busy_80, done_80, last_80}, 80'd0);
    check_eq("mid_rst_data", {cur_a(), cur_b(), row_idx_80, col_idx_80}, 80'd0);
    for (int k = 0; k < 16; k++) begin
      x_m[k] = 0; yc_m[k] = 0;
    end
    pulse_start();
    capture(-1, 0, -1, -1, -1);
    check_done_tail("zero");
    check_eq("zero_b0", {a_cap[0], b_cap[0]}, 80'd0);
    check_eq("zero_b15", {a_cap[15], b_cap[15]}, 80'd0);
    verify_beats("zero", 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
